seq_shifter: RTL and testbench

SEQ_SHIFTER -- requirements
Module: seq_shifter

---
 rtl/seq_shifter_pkg.sv | 25 ++
 rtl/seq_shifter_shift_step.sv | 46 ++++
 rtl/seq_shifter.sv | 134 +++++++++++++
 tb/tb_seq_shifter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/seq_shifter_pkg.sv
// Shared types for the multi-cycle shifter: operation codes and FSM states.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package seq_shifter_pkg;

  typedef enum logic [2:0] {
    F_SLL = 3'b000,
    F_SRL = 3'b001,
    F_SRA = 3'b010,
    F_ROL = 3'b011,
    F_ROR = 3'b100
  } funct_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Codes above ROR (101..111) are not operations.
  function automatic logic funct_legal(input logic [2:0] f);
    return (f <= 3'b100);
  endfunction

endpackage

// File: rtl/seq_shifter_shift_step.sv
// Combinational shift/rotate of WIDTH bits by a small amount (0..STEP).
// Latency: zero cycles (purely combinational).
// Backpressure: none; output follows inputs.
module shift_step
  import seq_shifter_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = 4
) (
  input  logic [WIDTH-1:0] i_data,
  input  logic [SHW-1:0]   i_amt,
  input  logic [2:0]       i_funct,
  output logic [WIDTH-1:0] o_data
);

  logic [SHW:0]     w_inv;
  logic [WIDTH-1:0] w_sll;
  logic [WIDTH-1:0] w_srl;
  logic [WIDTH-1:0] w_sra;
  logic [WIDTH-1:0] w_rol;
  logic [WIDTH-1:0] w_ror;

  // Complementary distance for rotates; equals WIDTH when i_amt is 0, so the
  // wrapped-around half shifts out completely and the rotate degenerates to identity.
  assign w_inv = (SHW+1)'(WIDTH) - {1'b0, i_amt};

  assign w_sll = i_data << i_amt;
  assign w_srl = i_data >> i_amt;
  assign w_sra = $signed(i_data) >>> i_amt;
  assign w_rol = (i_data << i_amt) | (i_data >> w_inv);
  assign w_ror = (i_data >> i_amt) | (i_data << w_inv);

  // Select the operation; illegal codes pass the operand through unchanged.
  always_comb begin
    o_data = i_data;
    case (i_funct)
      F_SLL:   o_data = w_sll;
      F_SRL:   o_data = w_srl;
      F_SRA:   o_data = w_sra;
      F_ROL:   o_data = w_rol;
      F_ROR:   o_data = w_ror;
      default: o_data = i_data;
    endcase
  end

endmodule

// File: rtl/seq_shifter.sv
// Iterative shifter: applies up to STEP bits of shift/rotate per cycle until shamt is consumed.
// Latency: max(1, ceil(shamt/STEP)) cycles from acceptance to out_valid; illegal funct takes 1.
// Backpressure: single in-flight op; in_ready only in IDLE, result held in DONE until out_ready.
module seq_shifter
  import seq_shifter_pkg::*;
#(
  parameter  int WIDTH = 16,
  parameter  int STEP  = 4,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] rs,
  input  logic [SHW-1:0]   shamt,
  input  logic [2:0]       funct,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             err
);

  localparam logic [SHW-1:0] STEP_AMT = SHW'(STEP);

  state_e           r_state;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_data;
  logic [SHW-1:0]   r_rem;
  logic [2:0]       r_op;
  logic             r_err;
  logic             r_zero;

  logic             w_idle;
  logic [WIDTH-1:0] w_src;
  logic [SHW-1:0]   w_rem_src;
  logic [2:0]       w_op;
  logic [SHW-1:0]   w_amt;
  logic [SHW-1:0]   w_rem_next;
  logic [WIDTH-1:0] w_step;

  // The acceptance edge doubles as the first shift step: operands come straight
  // from the request in IDLE and from the working registers afterwards. This is
  // what makes a shift of 1..STEP finish in a single cycle and lets an
  // op with out_ready held high recur every N+1 cycles.
  assign w_idle     = (r_state == ST_IDLE);
  assign w_src      = w_idle ? rs    : r_data;
  assign w_rem_src  = w_idle ? shamt : r_rem;
  assign w_op       = w_idle ? funct : r_op;
  assign w_amt      = (w_rem_src > STEP_AMT) ? STEP_AMT : w_rem_src;
  assign w_rem_next = w_rem_src - w_amt;

  shift_step #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_step (
    .i_data  (w_src),
    .i_amt   (w_amt),
    .i_funct (w_op),
    .o_data  (w_step)
  );

  // Control FSM with registered handshake outputs and result flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_data      <= '0;
      r_rem       <= '0;
      r_op        <= 3'b000;
      r_err       <= 1'b0;
      r_zero      <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_in_ready <= 1'b0;
            r_op       <= funct;
            if (!funct_legal(funct)) begin
              r_data      <= rs;
              r_rem       <= '0;
              r_err       <= 1'b1;
              r_zero      <= (rs == '0);
              r_out_valid <= 1'b1;
              r_state     <= ST_DONE;
            end else begin
              r_data <= w_step;
              r_rem  <= w_rem_next;
              r_err  <= 1'b0;
              if (w_rem_next == '0) begin
                r_zero      <= (w_step == '0);
                r_out_valid <= 1'b1;
                r_state     <= ST_DONE;
              end else begin
                r_state <= ST_SHIFT;
              end
            end
          end
        end
        ST_SHIFT: begin
          r_data <= w_step;
          r_rem  <= w_rem_next;
          if (w_rem_next == '0) begin
            r_zero      <= (w_step == '0);
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_data;
  assign zero      = r_zero;
  assign err       = r_err;

endmodule

// File: tb/tb_seq_shifter.sv
// Self-checking bench for seq_shifter (WIDTH=16, STEP=4).
// Latency: n/a.
// Backpressure: exercises out_ready stalls and reset mid-operation.
module tb_seq_shifter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] rs;
  logic [3:0]  shamt;
  logic [2:0]  funct;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        zero;
  logic        err;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [15:0] rs;
    logic [3:0]  shamt;
    logic [2:0]  funct;
    logic [15:0] res;
    logic        err;
    int          lat;
  } vec_t;

  typedef struct {
    logic [15:0] res;
    logic        err;
    logic        zero;
    int          lat;
  } exp_t;

  vec_t vecs[15];
  exp_t sb_q[$];

  seq_shifter #(.WIDTH(16), .STEP(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .rs        (rs),
    .shamt     (shamt),
    .funct     (funct),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Single-shot reference of the architectural operation.
  function automatic logic [15:0] ref_op(input logic [15:0] a, input logic [3:0] s, input logic [2:0] f);
    logic [4:0] inv;
    inv = 5'd16 - {1'b0, s};
    case (f)
      3'd0:    return a << s;
      3'd1:    return a >> s;
      3'd2:    return $signed(a) >>> s;
      3'd3:    return (a << s) | (a >> inv);
      3'd4:    return (a >> s) | (a << inv);
      default: return a;
    endcase
  endfunction

  task automatic run_op(input logic [15:0] a, input logic [3:0] s, input logic [2:0] f,
                        input logic [15:0] er, input logic ee, input int el, input string tag);
    exp_t e;
    exp_t g;
    int   n;
    @(negedge clk);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    rs = a; shamt = s; funct = f; in_valid = 1'b1;
    e.res = er; e.err = ee; e.zero = (er == 16'h0); e.lat = el;
    sb_q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    rs = 16'($urandom); shamt = 4'($urandom); funct = 3'($urandom);
    n = 1;
    while (!out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd1);
    g = sb_q.pop_front();
    if (out_valid) begin
      chk({tag, "_result"},  32'(result),   32'(g.res));
      chk({tag, "_err"},     32'(err),      32'(g.err));
      chk({tag, "_zero"},    32'(zero),     32'(g.zero));
      chk({tag, "_latency"}, 32'(n),        32'(g.lat));
      chk({tag, "_busy"},    32'(in_ready), 32'd0);
    end
    @(posedge clk); #1;
    chk({tag, "_release"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int seen;
    exp_t e;
    exp_t g;

    vecs[0]  = '{16'h0001, 4'd2,  3'b000, 16'h0004, 1'b0, 1};
    vecs[1]  = '{16'h8000, 4'd15, 3'b010, 16'hFFFF, 1'b0, 4};
    vecs[2]  = '{16'h8000, 4'd15, 3'b001, 16'h0001, 1'b0, 4};
    vecs[3]  = '{16'h0001, 4'd1,  3'b100, 16'h8000, 1'b0, 1};
    vecs[4]  = '{16'h8001, 4'd5,  3'b011, 16'h0030, 1'b0, 2};
    vecs[5]  = '{16'h0000, 4'd9,  3'b111, 16'h0000, 1'b1, 1};
    vecs[6]  = '{16'h1234, 4'd0,  3'b000, 16'h1234, 1'b0, 1};
    vecs[7]  = '{16'h7FF0, 4'd8,  3'b010, 16'h007F, 1'b0, 2};
    vecs[8]  = '{16'h1234, 4'd8,  3'b011, 16'h3412, 1'b0, 2};
    vecs[9]  = '{16'hABCD, 4'd4,  3'b100, 16'hDABC, 1'b0, 1};
    vecs[10] = '{16'hBEEF, 4'd3,  3'b101, 16'hBEEF, 1'b1, 1};
    vecs[11] = '{16'h0001, 4'd15, 3'b000, 16'h8000, 1'b0, 4};
    vecs[12] = '{16'h00F0, 4'd12, 3'b001, 16'h0000, 1'b0, 3};
    vecs[13] = '{16'hF000, 4'd13, 3'b010, 16'hFFFF, 1'b0, 4};
    vecs[14] = '{16'h0001, 4'd6,  3'b100, 16'h0400, 1'b0, 2};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    rs = 16'h0; shamt = 4'h0; funct = 3'b000;

    // Reset values
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result",    32'(result),    32'd0);
    chk("rst_zero",      32'(zero),      32'd1);
    chk("rst_err",       32'(err),       32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table
    for (int i = 0; i < 15; i++)
      run_op(vecs[i].rs, vecs[i].shamt, vecs[i].funct, vecs[i].res, vecs[i].err,
             vecs[i].lat, $sformatf("vec%0d", i));

    // Random operations against the single-shot reference
    for (int i = 0; i < 20; i++) begin
      logic [15:0] a;
      logic [3:0]  s;
      logic [2:0]  f;
      int          l;
      a = 16'($urandom); s = 4'($urandom); f = 3'($urandom);
      if (f > 3'd4) l = 1;
      else l = (s == 4'd0) ? 1 : (int'(s) + 3) / 4;
      run_op(a, s, f, ref_op(a, s, f), (f > 3'd4), l, $sformatf("rnd%0d", i));
    end

    // Backpressure: result held while out_ready low, extra requests ignored
    @(negedge clk);
    out_ready = 1'b0;
    rs = 16'h0003; shamt = 4'd1; funct = 3'b000; in_valid = 1'b1;
    e.res = 16'h0006; e.err = 1'b0; e.zero = 1'b0; e.lat = 1;
    sb_q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_out_valid", 32'(out_valid), 32'd1);
    g = sb_q.pop_front();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_valid = 1'b1; rs = 16'hFFFF; shamt = 4'd3; funct = 3'b001;
      @(posedge clk); #1;
      chk($sformatf("bp_hold_result%0d", k), 32'(result),    32'(g.res));
      chk($sformatf("bp_hold_valid%0d", k),  32'(out_valid), 32'd1);
      chk($sformatf("bp_in_ready%0d", k),    32'(in_ready),  32'd0);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_to_idle_valid", 32'(out_valid), 32'd0);
    chk("bp_to_idle_ready", 32'(in_ready),  32'd1);
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("bp_no_queued_req", 32'(seen), 32'd0);

    // Reset one cycle into SHIFT
    @(negedge clk);
    rs = 16'h0001; shamt = 4'd12; funct = 3'b000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("rs_busy_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk("rs_shift_valid", 32'(out_valid), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rs_out_valid", 32'(out_valid), 32'd0);
    chk("rs_result",    32'(result),    32'd0);
    chk("rs_zero",      32'(zero),      32'd1);
    chk("rs_err",       32'(err),       32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rs_in_ready", 32'(in_ready), 32'd1);
    // First edge after release must accept a new request
    rs = 16'h0001; shamt = 4'd2; funct = 3'b000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("rs_first_valid",  32'(out_valid), 32'd1);
    chk("rs_first_result", 32'(result),    32'h0004);
    @(posedge clk); #1;
    chk("rs_first_release", 32'(out_valid), 32'd0);
    seen = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("rs_no_stale", 32'(seen), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
